// File: rtl/pc_seq_pkg.sv
// Shared definitions for the next-PC sequencer: FSM encodings and parameter defaults.
package pc_seq_pkg;

  localparam int PC_W_DEF      = 8;
  localparam int CNT_W_DEF     = 16;
  localparam int RAS_DEPTH_DEF = 4;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_STALL  = 2'd1,
    ST_HALTED = 2'd2,
    ST_BOOT   = 2'd3
  } pc_state_e;

endpackage

// File: rtl/pc_seq_if.sv
// Decode/fetch-side bundle of the next-PC sequencer. Call/Ret/StackErr exist only
// when PCSEQ_RETSTACK_EN is defined.
// Handshake: no valid/ready pair; every input is sampled on each rising CLK and
// PCIN/Halt respond combinationally in the same cycle.
interface pc_seq_if #(
  parameter int PC_W  = pc_seq_pkg::PC_W_DEF,
  parameter int CNT_W = pc_seq_pkg::CNT_W_DEF
);
  logic [PC_W-1:0]  PC;
  logic             Stall;
  logic             HaltInstr;
  logic             Jump;
  logic             Branch;
  logic             Cond;
  logic [PC_W-1:0]  Target;
  logic             Resume;
  logic [PC_W-1:0]  PCIN;
  logic             Halt;
  logic             Flush;
  logic [1:0]       State;
  logic [CNT_W-1:0] FetchCount;
`ifdef PCSEQ_RETSTACK_EN
  logic             Call;
  logic             Ret;
  logic             StackErr;

  modport master (
    output PC, Stall, HaltInstr, Jump, Branch, Cond, Target, Resume, Call, Ret,
    input  PCIN, Halt, Flush, State, FetchCount, StackErr
  );
  modport slave (
    input  PC, Stall, HaltInstr, Jump, Branch, Cond, Target, Resume, Call, Ret,
    output PCIN, Halt, Flush, State, FetchCount, StackErr
  );
`else
  modport master (
    output PC, Stall, HaltInstr, Jump, Branch, Cond, Target, Resume,
    input  PCIN, Halt, Flush, State, FetchCount
  );
  modport slave (
    input  PC, Stall, HaltInstr, Jump, Branch, Cond, Target, Resume,
    output PCIN, Halt, Flush, State, FetchCount
  );
`endif
endinterface

// File: rtl/pc_return_stack.sv
// Circular return-address LIFO: a push when full overwrites the oldest entry, and a pop
// when empty returns zero. Both cases set the sticky err flag.
module pc_return_stack #(
  parameter int PC_W  = 8,
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  logic            pop,
  input  logic [PC_W-1:0] push_data,
  output logic [PC_W-1:0] pop_data,
  output logic            full,
  output logic            empty,
  output logic            err
);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [PC_W-1:0] mem [DEPTH];
  logic [IW-1:0]   top_q;   // next slot to write; top entry sits just below it
  logic [IW:0]     cnt_q;
  logic [IW-1:0]   top_prev;
  logic [IW-1:0]   top_next;

  assign top_prev = (top_q == '0) ? IW'(DEPTH - 1) : top_q - 1'b1;
  assign top_next = (top_q == IW'(DEPTH - 1)) ? '0 : top_q + 1'b1;
  assign full     = (cnt_q == (IW+1)'(DEPTH));
  assign empty    = (cnt_q == '0);
  assign pop_data = empty ? '0 : mem[top_prev];

  always_ff @(posedge clk) begin
    if (push) mem[top_q] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      top_q <= '0;
      cnt_q <= '0;
      err   <= 1'b0;
    end else if (push) begin
      top_q <= top_next;
      if (full) err <= 1'b1;
      else      cnt_q <= cnt_q + 1'b1;
    end else if (pop) begin
      if (empty) begin
        err <= 1'b1;
      end else begin
        top_q <= top_prev;
        cnt_q <= cnt_q - 1'b1;
      end
    end
  end
endmodule

// File: rtl/pc_sequencer.sv
// Next-PC controller with BOOT/RUN/STALL/HALTED FSM, Flush pulse and fetch counter.
// Optional return stack (Call/Ret/StackErr) is built when PCSEQ_RETSTACK_EN is defined.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int PC_W      = PC_W_DEF,
  parameter int CNT_W     = CNT_W_DEF,
  parameter int RAS_DEPTH = RAS_DEPTH_DEF
) (
  input logic    CLK,
  input logic    Init,
  pc_seq_if.slave bus
);
  localparam logic [1:0] RUN    = ST_RUN;
  localparam logic [1:0] STALL  = ST_STALL;
  localparam logic [1:0] HALTED = ST_HALTED;
  localparam logic [1:0] BOOT   = ST_BOOT;

  logic [1:0]       state_q, state_d;
  logic             flush_q;
  logic [CNT_W-1:0] cnt_q;
  logic [PC_W-1:0]  pcin;
  logic [PC_W-1:0]  pc_inc;
  logic             halt;
  logic             redirect;

`ifdef PCSEQ_RETSTACK_EN
  logic            push, pop;
  logic [PC_W-1:0] pop_data;
  logic            stack_err;

  pc_return_stack #(.PC_W(PC_W), .DEPTH(RAS_DEPTH)) u_ras (
    .clk       (CLK),
    .rst       (Init),
    .push      (push),
    .pop       (pop),
    .push_data (pc_inc),
    .pop_data  (pop_data),
    .full      (),
    .empty     (),
    .err       (stack_err)
  );
  assign bus.StackErr = stack_err;
`endif

  assign pc_inc = bus.PC + 1'b1;

  always_comb begin
    halt     = 1'b0;
    pcin     = bus.PC;
    redirect = 1'b0;
    state_d  = state_q;
`ifdef PCSEQ_RETSTACK_EN
    push     = 1'b0;
    pop      = 1'b0;
`endif
    case (state_q)
      BOOT: begin
        halt    = 1'b1;
        state_d = RUN;
      end
      HALTED: begin
        halt = 1'b1;
        if (bus.Resume) state_d = RUN;
      end
      default: begin
        // RUN, and STALL once Stall drops, share one priority list with no bubble
        if (bus.Stall) begin
          halt    = 1'b1;
          state_d = STALL;
        end else if (bus.HaltInstr) begin
          halt    = 1'b1;
          state_d = HALTED;
        end
`ifdef PCSEQ_RETSTACK_EN
        else if (bus.Call) begin
          push     = 1'b1;
          pcin     = bus.Target;
          redirect = 1'b1;
        end else if (bus.Ret) begin
          pop      = 1'b1;
          pcin     = pop_data;
          redirect = 1'b1;
        end
`endif
        else if (bus.Jump || (bus.Branch && bus.Cond)) begin
          pcin     = bus.Target;
          redirect = 1'b1;
        end else begin
          pcin = pc_inc;
        end
        if (!halt) state_d = RUN;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (Init) begin
      state_q <= BOOT;
      flush_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      flush_q <= redirect;
      if ((state_q == RUN || state_q == STALL) && !halt && cnt_q != {CNT_W{1'b1}})
        cnt_q <= cnt_q + 1'b1;
    end
  end

  assign bus.PCIN       = pcin;
  assign bus.Halt       = halt;
  assign bus.Flush      = flush_q;
  assign bus.State      = state_q;
  assign bus.FetchCount = cnt_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: the driver pushes hand-computed expectations per cycle,
// and a monitor pops and compares them late in the same cycle.
module tb_pc_sequencer;
  localparam int W = 29;  // {err, cnt[15:0], state[1:0], flush, halt, pcin[7:0]}

  localparam logic [7:0] C_STALL = 8'h01;
  localparam logic [7:0] C_HALTI = 8'h02;
  localparam logic [7:0] C_JMP   = 8'h04;
  localparam logic [7:0] C_BR    = 8'h08;
  localparam logic [7:0] C_COND  = 8'h10;
  localparam logic [7:0] C_RES   = 8'h20;
  localparam logic [7:0] C_CALL  = 8'h40;
  localparam logic [7:0] C_RET   = 8'h80;

  logic CLK = 1'b0;
  logic Init;
  int   tests = 0;
  int   fails = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] msk_q[$];
  string        name_q[$];

  pc_seq_if #(.PC_W(8), .CNT_W(16)) bus ();

  pc_sequencer #(.PC_W(8), .CNT_W(16), .RAS_DEPTH(4)) dut (
    .CLK  (CLK),
    .Init (Init),
    .bus  (bus)
  );

  always #5 CLK = ~CLK;

  // Driver: one call = one cycle of inputs plus the expected outputs for that cycle.
  task automatic step(input string nm, input logic ini, input logic [7:0] pc,
                      input logic [7:0] ctl, input logic [7:0] tgt,
                      input logic [7:0] e_pcin, input logic e_halt, input logic e_flush,
                      input logic [1:0] e_state, input logic [15:0] e_cnt,
                      input logic e_err, input logic chk_cnt, input logic chk_err);
    @(negedge CLK);
    Init          = ini;
    bus.PC        = pc;
    bus.Stall     = ctl[0];
    bus.HaltInstr = ctl[1];
    bus.Jump      = ctl[2];
    bus.Branch    = ctl[3];
    bus.Cond      = ctl[4];
    bus.Resume    = ctl[5];
`ifdef PCSEQ_RETSTACK_EN
    bus.Call      = ctl[6];
    bus.Ret       = ctl[7];
`endif
    bus.Target    = tgt;
    exp_q.push_back({e_err, e_cnt, e_state, e_flush, e_halt, e_pcin});
    msk_q.push_back({chk_err, {16{chk_cnt}}, 2'b11, 1'b1, 1'b1, 8'hFF});
    name_q.push_back(nm);
  endtask

  // Monitor: compares shortly before the next rising edge, after inputs have settled.
  initial begin
    logic [W-1:0] e, m, a;
    string n;
    logic err_bit;
    forever begin
      @(negedge CLK);
      #4;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        m = msk_q.pop_front();
        n = name_q.pop_front();
`ifdef PCSEQ_RETSTACK_EN
        err_bit = bus.StackErr;
`else
        err_bit = 1'b0;
`endif
        a = {err_bit, bus.FetchCount, bus.State, bus.Flush, bus.Halt, bus.PCIN};
        tests++;
        if ((a & m) !== (e & m)) begin
          fails++;
          $display("FAIL %s: got err=%0b cnt=%0d st=%0d fl=%0b h=%0b pcin=%h, exp err=%0b cnt=%0d st=%0d fl=%0b h=%0b pcin=%h (mask %h)",
                   n, a[28], a[27:12], a[11:10], a[9], a[8], a[7:0],
                   e[28], e[27:12], e[11:10], e[9], e[8], e[7:0], m);
        end
      end
    end
  end

  initial begin
    int budget;
    Init = 1'b1;
    bus.PC = '0; bus.Stall = 0; bus.HaltInstr = 0; bus.Jump = 0; bus.Branch = 0;
    bus.Cond = 0; bus.Target = '0; bus.Resume = 0;
`ifdef PCSEQ_RETSTACK_EN
    bus.Call = 0; bus.Ret = 0;
`endif
    repeat (2) @(posedge CLK);

    //    name        ini  pc     ctl                      tgt    pcin  h  fl st cnt  err cc ce
    step("reset",      1, 8'h00, 8'h00,                   8'h00, 8'h00, 1, 0, 3, 0,  0, 1, 0);
    step("boot",       0, 8'h00, 8'h00,                   8'h00, 8'h00, 1, 0, 3, 0,  0, 1, 0);
    step("run0",       0, 8'h00, 8'h00,                   8'h00, 8'h01, 0, 0, 0, 0,  0, 1, 0);
    step("run1",       0, 8'h01, 8'h00,                   8'h00, 8'h02, 0, 0, 0, 1,  0, 1, 0);
    step("wrap",       0, 8'hFF, 8'h00,                   8'h00, 8'h00, 0, 0, 0, 2,  0, 1, 0);
    step("jump",       0, 8'h10, C_JMP,                   8'h40, 8'h40, 0, 0, 0, 3,  0, 1, 0);
    step("br_nt",      0, 8'h40, C_BR,                    8'h77, 8'h41, 0, 1, 0, 4,  0, 1, 0);
    step("br_nt_nofl", 0, 8'h41, 8'h00,                   8'h00, 8'h42, 0, 0, 0, 5,  0, 1, 0);
    step("stall0",     0, 8'h22, C_STALL,                 8'h00, 8'h22, 1, 0, 0, 6,  0, 1, 0);
    step("stall1",     0, 8'h22, C_STALL,                 8'h00, 8'h22, 1, 0, 1, 6,  0, 1, 0);
    step("stall2",     0, 8'h22, C_STALL,                 8'h00, 8'h22, 1, 0, 1, 6,  0, 1, 0);
    step("stall_br",   0, 8'h22, C_BR | C_COND,           8'h05, 8'h05, 0, 0, 1, 6,  0, 1, 0);
    step("after_br",   0, 8'h05, 8'h00,                   8'h00, 8'h06, 0, 1, 0, 7,  0, 1, 0);
    step("haltinstr",  0, 8'h30, C_HALTI,                 8'h00, 8'h30, 1, 0, 0, 8,  0, 1, 0);
    for (int i = 0; i < 10; i++)
      step("halted",   0, 8'h30, C_JMP | C_STALL | C_BR | C_COND, 8'h99, 8'h30, 1, 0, 2, 8, 0, 1, 0);
    step("resume",     0, 8'h30, C_RES,                   8'h00, 8'h30, 1, 0, 2, 8,  0, 1, 0);
    step("resumed",    0, 8'h30, 8'h00,                   8'h00, 8'h31, 0, 0, 0, 8,  0, 1, 0);
    step("halt2",      0, 8'h31, C_HALTI,                 8'h00, 8'h31, 1, 0, 0, 9,  0, 1, 0);
    step("halted2",    0, 8'h31, C_JMP,                   8'h50, 8'h31, 1, 0, 2, 9,  0, 1, 0);
    step("init_halt",  1, 8'h31, 8'h00,                   8'h00, 8'h31, 1, 0, 2, 9,  0, 1, 0);
    step("reboot",     0, 8'h00, 8'h00,                   8'h00, 8'h00, 1, 0, 3, 0,  0, 1, 0);
`ifdef PCSEQ_RETSTACK_EN
    step("call1",      0, 8'h01, C_CALL,                  8'h10, 8'h10, 0, 0, 0, 0,  0, 0, 1);
    step("call2",      0, 8'h02, C_CALL,                  8'h10, 8'h10, 0, 1, 0, 0,  0, 0, 1);
    step("call3",      0, 8'h03, C_CALL,                  8'h10, 8'h10, 0, 1, 0, 0,  0, 0, 1);
    step("call4",      0, 8'h04, C_CALL,                  8'h10, 8'h10, 0, 1, 0, 0,  0, 0, 1);
    step("call5",      0, 8'h05, C_CALL | C_RET,          8'h10, 8'h10, 0, 1, 0, 0,  0, 0, 1);
    step("ret1",       0, 8'h10, C_RET,                   8'h00, 8'h06, 0, 1, 0, 0,  1, 0, 1);
    step("ret2",       0, 8'h06, C_RET,                   8'h00, 8'h05, 0, 1, 0, 0,  1, 0, 1);
    step("ret3",       0, 8'h05, C_RET,                   8'h00, 8'h04, 0, 1, 0, 0,  1, 0, 1);
    step("ret4",       0, 8'h04, C_RET,                   8'h00, 8'h03, 0, 1, 0, 0,  1, 0, 1);
    step("ret_empty",  0, 8'h03, C_RET,                   8'h00, 8'h00, 0, 1, 0, 0,  1, 0, 1);
`endif

    budget = 20;
    while (exp_q.size() > 0 && budget > 0) begin
      @(negedge CLK);
      budget--;
    end
    @(posedge CLK);
    if (exp_q.size() > 0) begin
      tests++;
      fails++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Next-PC controller for the 8-bit fetch register of the 10-bit CPU. It computes PCIN from the current PC and the decoder's control-flow signals, and drives the fetch register's Halt input. It owns the run/stall/halt state machine and a retired-fetch counter. It sits between decode and the fetch register and shares CLK/Init with the fetch register.

Parameters:
PC_W, 8, program counter width
CNT_W, 16, width of the fetch counter
RAS_DEPTH, 4, return-stack entries (used only with the optional feature)

Ports:
CLK  in  1  system clock, rising edge
Init  in  1  synchronous active-high reset, shared with the fetch register
PC  in  PC_W  current PC from the fetch register
Stall  in  1  hazard stall from decode
HaltInstr  in  1  decoded HALT opcode
Jump  in  1  unconditional jump decoded
Branch  in  1  conditional branch decoded
Cond  in  1  branch condition true
Target  in  PC_W  jump/branch/call target
Resume  in  1  external restart from HALTED
PCIN  out  PC_W  next PC to the fetch register
Halt  out  1  freeze request to the fetch register
Flush  out  1  one-cycle pulse, cycle after a taken redirect
State  out  2  FSM state, for debug
FetchCount  out  CNT_W  fetches advanced since Init

Behaviour:
- Reset: Init=1 at posedge puts State=BOOT, Flush=0 and FetchCount=0. The fetch register zeroes PC on the same edge.
- Encoding: RUN=0, STALL=1, HALTED=2, BOOT=3.
- BOOT: Halt=1 and PCIN=PC for exactly one cycle, then go to RUN unconditionally. This cycle is the instruction-memory first-read slot.
- RUN (combinational PCIN, fixed priority):
  - Stall: Halt=1, PCIN=PC, go to STALL.
  - Else HaltInstr: Halt=1, PCIN=PC, go to HALTED.
  - Else Jump: PCIN=Target.
  - Else Branch&Cond: PCIN=Target.
  - Else: PCIN=PC+1, wrapping modulo 2^PC_W (0xFF -> 0x00, no flag).
  - When Halt=0, go to RUN next.
- STALL: Halt=1 and PCIN=PC while Stall=1. When Stall=0, evaluate the RUN priority list this same cycle; there is no extra bubble.
- HALTED:
  - Halt=1 and PCIN=PC.
  - Resume=1 moves to RUN next cycle with PC unchanged, so the HALT instruction is re-fetched.
  - Decode must not reassert HaltInstr on that re-fetch until PC moves. In practice the resume vector is applied by a Jump in the first RUN cycle.
  - Stall, Jump and Branch are ignored.
- Flush: registered. It is 1 in the cycle after any cycle where RUN took a Jump or a taken Branch, otherwise 0.
- Branch with Cond=0 is not a redirect and gives PC+1 with no Flush.
- FetchCount: increments on every posedge where State is RUN or STALL and Halt=0. It saturates at 2^CNT_W-1.
- Init asserted in any state, mid-stall or mid-halt, wins over everything. The outputs follow the reset values above on the next edge.

Optional Feature:
Macro PCSEQ_RETSTACK_EN.
- Defined:
  - Adds inputs Call and Ret (1 bit each) and output StackErr (1 bit, sticky, cleared by Init).
  - Call ranks in RUN priority just after HaltInstr: push PC+1 and set PCIN=Target.
  - Ret ranks after Call: pop and set PCIN=popped value.
  - Both count as redirects for Flush.
  - Push when full overwrites the oldest entry (circular) and sets StackErr.
  - Pop when empty gives PCIN=0 and sets StackErr.
  - Call and Ret in the same cycle: Call wins and Ret is ignored.
  - Init empties the stack.
- Undefined: the ports and storage are absent, and the behaviour is as above.

Decomposition:
- Shared package pc_seq_pkg holds:
  - state enum and encodings (RUN/STALL/HALTED/BOOT)
  - PC_W and CNT_W defaults
  - RAS_DEPTH default
- One sub-module, pc_return_stack: a circular LIFO with push/pop, full/empty and error output. It is instantiated only under PCSEQ_RETSTACK_EN.

Test Plan:
- Init for 2 cycles, then release -> State=BOOT for 1 cycle with Halt=1, then RUN. PCIN=0x01 when PC=0x00, and FetchCount increments from 0.
- PC=0xFF in RUN with no controls -> PCIN=0x00 with no Flush.
- PC=0x10, Jump=1, Target=0x40 -> PCIN=0x40 and Flush=1 the next cycle. Then Branch=1 with Cond=0 at PC=0x40 -> PCIN=0x41 and Flush stays 0.
- Stall=1 for 3 cycles at PC=0x22, then Stall=0 with Branch=1, Cond=1, Target=0x05 -> Halt=1 for 3 cycles and FetchCount frozen, then PCIN=0x05 immediately.
- HaltInstr=1 at PC=0x30 -> HALTED, with Halt=1 held 10 cycles despite Jump=1. Resume=1 -> RUN next cycle with PCIN=0x31. Init during HALTED -> BOOT.
- With PCSEQ_RETSTACK_EN: 5 Calls from PC=0x01..0x05 -> fifth sets StackErr. Four Rets then return 0x06, 0x05, 0x04, 0x03. Fifth Ret gives PCIN=0x00.
